display_scan_ctrl: RTL and testbench

//  Time-multiplexes a 16-bit value (4 hex digits) onto a 4-digit common-anode 7-seg display.

---
 rtl/display_scan_ctrl_pkg.sv | 42 ++++
 rtl/display_scan_ctrl_if.sv | 18 +
 rtl/display_scan_ctrl_hex_to_seg7.sv | 37 +++
 rtl/display_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the 7-segment display path. The scan word is
// {anode_sel[3:0], seg[7:0]}, all active-low, seg = {dp,g,f,e,d,c,b,a}.
// No ports (package).
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int SCAN_W = 12;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_B     = 8'h83;
   localparam logic [7:0] SEG_C     = 8'hC6;
   localparam logic [7:0] SEG_D     = 8'hA1;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] ANODE_D1   = 4'b1110;
   localparam logic [3:0] ANODE_D2   = 4'b1101;
   localparam logic [3:0] ANODE_D3   = 4'b1011;
   localparam logic [3:0] ANODE_D4   = 4'b0111;
   localparam logic [3:0] ANODE_NONE = 4'hF;

   typedef enum logic [1:0] {
      SLOT_D1 = 2'd0,
      SLOT_D2 = 2'd1,
      SLOT_D3 = 2'd2,
      SLOT_D4 = 2'd3
   } slot_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Value handshake between the CPU/debug bus (master) and the scan controller
// (slave).
//   value_in[15:0]  hex value, [3:0] = rightmost digit
//   value_valid     value_in offered this cycle
//   value_ready     controller can accept value_in
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if;

   logic [15:0] value_in;
   logic        value_valid;
   logic        value_ready;

   modport master (output value_in, output value_valid, input value_ready);
   modport slave  (input value_in, input value_valid, output value_ready);

endinterface

// File: rtl/display_scan_ctrl_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble to active-low 7-segment pattern, dp always off (1).
//   nibble[3:0]  hex digit
//   seg[7:0]     {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexes a 16-bit value onto a 4-digit common-anode 7-seg display.
// New values are held in a one-deep pending register and only copied into the
// displayed value at the frame boundary (digit4 -> digit1), so a frame never
// mixes digits of two values.
//
// Parameters
//   TICK_DIV     clk cycles per digit slot (>= 1)
// Ports
//   clk          system clock
//   reset        synchronous reset, active-high
//   val_if       slave side of display_scan_ctrl_if (value_in/valid/ready)
//   digi_out     {anode_sel[3:0], seg[7:0]}, active-low, registered
//   frame_done   1-cycle pulse the cycle after the digit4 -> digit1 wrap
// Build option
//   LEADING_ZERO_BLANK_EN  blank digits above the most-significant nonzero
//                          nibble (digit1 always shown)
//
// Slot FSM
//   state   | meaning
//   SLOT_D1 | scanning digit1 (rightmost), anode 1110
//   SLOT_D2 | scanning digit2, anode 1101
//   SLOT_D3 | scanning digit3, anode 1011
//   SLOT_D4 | scanning digit4, anode 0111; wrap here is the frame boundary
// -----------------------------------------------------------------------------
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   display_scan_ctrl_if.slave    val_if,
   output logic [SCAN_W-1:0]     digi_out,
   output logic                  frame_done
);

   // TICK_DIV=1 still needs a 1-bit counter that is permanently at its last value.
   localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic             boundary;
   slot_t            slot;
   slot_t            slot_nxt;
   logic [3:0]       anode;
   logic [3:0]       nibble;
   logic [7:0]       seg_raw;
   logic [7:0]       seg_sel;
   logic [15:0]      disp;
   logic [15:0]      pending;
   logic             pending_full;
   logic             capture;

   assign wrap     = (cnt == CNT_LAST);
   assign boundary = wrap && (slot == SLOT_D4);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot <= SLOT_D1;
      end else begin
         slot <= slot_nxt;
      end
   end

   always_comb begin
      slot_nxt = slot;
      anode    = ANODE_D1;
      nibble   = disp[3:0];
      case (slot)
         SLOT_D1: begin
            anode  = ANODE_D1;
            nibble = disp[3:0];
            if (wrap) slot_nxt = SLOT_D2;
         end
         SLOT_D2: begin
            anode  = ANODE_D2;
            nibble = disp[7:4];
            if (wrap) slot_nxt = SLOT_D3;
         end
         SLOT_D3: begin
            anode  = ANODE_D3;
            nibble = disp[11:8];
            if (wrap) slot_nxt = SLOT_D4;
         end
         SLOT_D4: begin
            anode  = ANODE_D4;
            nibble = disp[15:12];
            if (wrap) slot_nxt = SLOT_D1;
         end
         default: slot_nxt = SLOT_D1;
      endcase
   end

   // Ready is simply "pending slot empty"; a capture can therefore never
   // coincide with a pending->disp transfer, and a capture on the boundary
   // cycle waits for the following boundary.
   assign capture            = val_if.value_valid && !pending_full;
   assign val_if.value_ready = !pending_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         disp         <= 16'h0000;
         pending      <= 16'h0000;
         pending_full <= 1'b0;
      end else begin
         if (boundary && pending_full) begin
            disp         <= pending;
            pending_full <= 1'b0;
         end
         if (capture) begin
            pending      <= val_if.value_in;
            pending_full <= 1'b1;
         end
      end
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (seg_raw)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [1:0] msd;
   logic [1:0] slot_idx;

   assign slot_idx = slot;

   always_comb begin
      msd = 2'd0;
      if (disp[7:4]   != 4'h0) msd = 2'd1;
      if (disp[11:8]  != 4'h0) msd = 2'd2;
      if (disp[15:12] != 4'h0) msd = 2'd3;
   end

   assign seg_sel = (slot_idx > msd) ? SEG_BLANK : seg_raw;
`else
   assign seg_sel = seg_raw;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         digi_out   <= {ANODE_NONE, SEG_BLANK};
         frame_done <= 1'b0;
      end else begin
         digi_out   <= {anode, seg_sel};
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Two instances share clk/reset: u_dut0 with TICK_DIV=4 and u_dut1 with
// TICK_DIV=1. The reference model derives slot, boundary and expected scan
// word from the edge count since reset using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] digi0, digi1;
   logic        fd0, fd1;

   always #5 clk = ~clk;

   display_scan_ctrl_if if0 ();
   display_scan_ctrl_if if1 ();

   display_scan_ctrl #(.TICK_DIV(4)) u_dut0 (
      .clk        (clk),
      .reset      (rst),
      .val_if     (if0.slave),
      .digi_out   (digi0),
      .frame_done (fd0)
   );

   display_scan_ctrl #(.TICK_DIV(1)) u_dut1 (
      .clk        (clk),
      .reset      (rst),
      .val_if     (if1.slave),
      .digi_out   (digi1),
      .frame_done (fd1)
   );

   logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   int          n_pass = 0;
   int          n_total = 0;
   int          n_fail = 0;

   int          m_t    [2];
   logic [15:0] m_disp [2];
   logic [15:0] m_pend [2];
   bit          m_full [2];
   logic [11:0] m_digi [2];
   bit          m_fd   [2];
   logic [7:0]  seen   [2][4];

   function automatic logic [7:0] exp_seg(logic [15:0] d, int slot);
      int         msd = 0;
      logic [3:0] nib;
      for (int i = 0; i < 4; i++)
         if (((d >> (4 * i)) & 16'hF) != 16'h0) msd = i;
      nib = 4'((d >> (4 * slot)) & 16'hF);
      if (BLANK_EN && slot > msd) return 8'hFF;
      return seg_tbl[nib];
   endfunction

   task automatic model_edge(int k, bit r, bit v, logic [15:0] d);
      int td, slot;
      bit bnd, old_full;
      if (r) begin
         m_t[k] = 0; m_disp[k] = 16'h0; m_pend[k] = 16'h0; m_full[k] = 1'b0;
         m_digi[k] = 12'hFFF; m_fd[k] = 1'b0;
         return;
      end
      td        = (k == 0) ? 4 : 1;
      slot      = (m_t[k] / td) % 4;
      m_digi[k] = {~(4'b0001 << slot), exp_seg(m_disp[k], slot)};
      bnd       = (m_t[k] % (4 * td)) == (4 * td - 1);
      m_fd[k]   = bnd;
      old_full  = m_full[k];
      if (bnd && old_full) begin
         m_disp[k] = m_pend[k];
         m_full[k] = 1'b0;
      end
      if (v && !old_full) begin
         m_pend[k] = d;
         m_full[k] = 1'b1;
      end
      m_t[k]++;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0, rst, if0.value_valid, if0.value_in);
      model_edge(1, rst, if1.value_valid, if1.value_in);
      #1;
      chk("digi0",  32'(digi0),             32'(m_digi[0]));
      chk("fd0",    32'(fd0),               32'(m_fd[0]));
      chk("ready0", 32'(if0.value_ready),   32'(!m_full[0]));
      chk("digi1",  32'(digi1),             32'(m_digi[1]));
      chk("fd1",    32'(fd1),               32'(m_fd[1]));
      chk("ready1", 32'(if1.value_ready),   32'(!m_full[1]));
   endtask

   task automatic wait_ready(int k);
      int i = 0;
      while (i < 64 && ((k == 0) ? !if0.value_ready : !if1.value_ready)) begin
         step();
         i++;
      end
      chk("wait_ready", 32'((k == 0) ? if0.value_ready : if1.value_ready), 32'd1);
   endtask

   task automatic wait_phase0(int ph);
      int i = 0;
      while (i < 32 && (m_t[0] % 16) != ph) begin
         step();
         i++;
      end
      chk("wait_phase", 32'(m_t[0] % 16), 32'(ph));
   endtask

   task automatic collect(int k, int n);
      logic [11:0] w;
      for (int j = 0; j < 4; j++) seen[k][j] = 8'h00;
      for (int i = 0; i < n; i++) begin
         step();
         w = (k == 0) ? digi0 : digi1;
         case (w[11:8])
            4'b1110: seen[k][0] = w[7:0];
            4'b1101: seen[k][1] = w[7:0];
            4'b1011: seen[k][2] = w[7:0];
            4'b0111: seen[k][3] = w[7:0];
            default: ;
         endcase
      end
   endtask

   task automatic fd_period(int k, int per);
      int last = -1;
      int hits = 0;
      for (int i = 0; i < 3 * per + 1; i++) begin
         step();
         if ((k == 0) ? fd0 : fd1) begin
            if (last >= 0) chk("fd_period", 32'(i - last), 32'(per));
            last = i;
            hits++;
         end
      end
      chk("fd_hits", 32'(hits >= 2), 32'd1);
   endtask

   initial begin
      logic [7:0] e34;
      e34 = BLANK_EN ? 8'hFF : 8'hC0;
      rst = 1'b1;
      if0.value_valid = 1'b0; if0.value_in = 16'h0;
      if1.value_valid = 1'b0; if1.value_in = 16'h0;

      // reset and first scan word
      repeat (3) begin
         step();
         chk("rst_digi", 32'(digi0), 32'hFFF);
         chk("rst_ready", 32'(if0.value_ready), 32'd1);
      end
      rst = 1'b0;
      step();
      chk("first_scan", 32'(digi0), 32'hEC0);

      // 12AF full frame, frame_done spacing
      if0.value_in = 16'h12AF; if0.value_valid = 1'b1;
      step();
      if0.value_valid = 1'b0;
      wait_ready(0);
      collect(0, 16);
      chk("12af_d1", 32'({4'b1110, seen[0][0]}), 32'hE8E);
      chk("12af_d2", 32'({4'b1101, seen[0][1]}), 32'hD88);
      chk("12af_d3", 32'({4'b1011, seen[0][2]}), 32'hBA4);
      chk("12af_d4", 32'({4'b0111, seen[0][3]}), 32'h7F9);
      fd_period(0, 16);

      // valid while not ready is ignored
      wait_phase0(1);
      if0.value_in = 16'h1111; if0.value_valid = 1'b1;
      step();
      if0.value_in = 16'h2222;
      step();
      step();
      if0.value_valid = 1'b0;
      wait_ready(0);
      collect(0, 16);
      for (int j = 0; j < 4; j++) chk("ignore_2222", 32'(seen[0][j]), 32'hF9);

      // capture on the boundary cycle waits one extra frame
      wait_phase0(15);
      if0.value_in = 16'hABCD; if0.value_valid = 1'b1;
      step();
      if0.value_valid = 1'b0;
      collect(0, 16);
      for (int j = 0; j < 4; j++) chk("bnd_hold_old", 32'(seen[0][j]), 32'hF9);
      collect(0, 16);
      chk("bnd_new_d1", 32'(seen[0][0]), 32'hA1);
      chk("bnd_new_d2", 32'(seen[0][1]), 32'hC6);
      chk("bnd_new_d3", 32'(seen[0][2]), 32'h83);
      chk("bnd_new_d4", 32'(seen[0][3]), 32'h88);

      // reset mid-slot-2 with a pending value
      wait_phase0(1);
      if0.value_in = 16'h5678; if0.value_valid = 1'b1;
      step();
      if0.value_valid = 1'b0;
      chk("pend_full", 32'(if0.value_ready), 32'd0);
      wait_phase0(9);
      rst = 1'b1;
      step();
      chk("midrst_digi", 32'(digi0), 32'hFFF);
      chk("midrst_ready", 32'(if0.value_ready), 32'd1);
      rst = 1'b0;
      step();
      chk("midrst_scan", 32'(digi0), 32'hEC0);
      collect(0, 16);
      chk("zero_d1", 32'(seen[0][0]), 32'hC0);
      chk("zero_d4", 32'(seen[0][3]), 32'(e34));

      // TICK_DIV=1 instance, 0x0050
      if1.value_in = 16'h0050; if1.value_valid = 1'b1;
      step();
      if1.value_valid = 1'b0;
      wait_ready(1);
      collect(1, 4);
      chk("d50_d1", 32'(seen[1][0]), 32'hC0);
      chk("d50_d2", 32'(seen[1][1]), 32'h92);
      chk("d50_d3", 32'(seen[1][2]), 32'(e34));
      chk("d50_d4", 32'(seen[1][3]), 32'(e34));
      fd_period(1, 4);

      // random traffic on both instances
      for (int i = 0; i < 600; i++) begin
         if0.value_valid = ($urandom_range(0, 7) == 0);
         if0.value_in    = 16'($urandom);
         if1.value_valid = ($urandom_range(0, 3) == 0);
         if1.value_in    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         if (i == 300) rst = 1'b1;
         step();
         rst = 1'b0;
      end
      if0.value_valid = 1'b0;
      if1.value_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
